// File: rtl/fp32_pkg.sv
// binary32 field layout, constants, FSM state type and operand-decode helpers
// shared by the sequential subtractor and its aligner.
package fp32_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS  = 127;

   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
   localparam logic [31:0]      QNAN    = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ALIGN = 3'd1,
      ADD   = 3'd2,
      NORM  = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] frac;
   } f32_t;

   // Denormals are treated as zero, so the hidden bit is simply exp != 0.
   function automatic logic [MAN_W:0] f32_mant(input f32_t f);
      return (f.exp == '0) ? '0 : {1'b1, f.frac};
   endfunction

   function automatic logic f32_is_nan(input f32_t f);
      return (f.exp == EXP_MAX) && (f.frac != '0);
   endfunction

   function automatic logic f32_is_inf(input f32_t f);
      return (f.exp == EXP_MAX) && (f.frac == '0);
   endfunction

   function automatic logic f32_is_zero(input f32_t f);
      return f.exp == '0;
   endfunction

endpackage

// File: rtl/f32_align.sv
// Combinational 24b mantissa right shifter; shifts of 24 or more give zero.
// Discarded low bits are truncated.
module f32_align
   import fp32_pkg::*;
(
   input  logic [MAN_W:0]   m_in,
   input  logic [EXP_W-1:0] shamt,
   output logic [MAN_W:0]   m_out
);

   always_comb begin
      m_out = '0;
      if (shamt < 8'd24) begin
         m_out = m_in >> shamt[4:0];
      end
   end

endmodule

// File: rtl/subf32_seq.sv
// Sequential binary32 subtractor diff = a - b: out_valid 3 edges after accept (2 for specials) plus one per normalise shift.
// One operation in flight: in_ready only in IDLE; out_valid and diff hold until out_ready.
module subf32_seq
   import fp32_pkg::*;
#(
   parameter int          MAX_NORM = 23,
   parameter logic [31:0] NAN_CODE = QNAN
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] diff,
   output logic        busy
);

   state_t           state_q, state_d;
   f32_t             opa_q, opa_d, opb_q, opb_d;
   logic             s_q, s_d, sub_q, sub_d;
   logic [EXP_W-1:0] e_q, e_d;
   logic [MAN_W+1:0] ml_q, ml_d, ms_q, ms_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [31:0]      diff_q, diff_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   logic             swap;
   f32_t             op_l, op_s;
   logic [MAN_W:0]   man_l, man_s, man_s_sh;
   logic [EXP_W-1:0] shamt, e_dec;
   logic             nan_any, inf_clash;
   logic [MAN_W+1:0] sum, dif, m_sh;

   // Magnitude order: exponent first, then mantissa, in a single compare.
   assign swap  = {opb_q.exp, f32_mant(opb_q)} > {opa_q.exp, f32_mant(opa_q)};
   assign op_l  = swap ? opb_q : opa_q;
   assign op_s  = swap ? opa_q : opb_q;
   assign man_l = f32_mant(op_l);
   assign man_s = f32_mant(op_s);
   assign shamt = op_l.exp - op_s.exp;

   f32_align u_align (
      .m_in  (man_s),
      .shamt (shamt),
      .m_out (man_s_sh)
   );

   assign nan_any   = f32_is_nan(opa_q) | f32_is_nan(opb_q);
   assign inf_clash = f32_is_inf(opa_q) & f32_is_inf(opb_q) & (opa_q.sign ^ opb_q.sign);

   assign sum   = ml_q + ms_q;
   assign dif   = ml_q - ms_q;
   assign m_sh  = {ml_q[MAN_W:0], 1'b0};
   assign e_dec = e_q - 8'd1;

   assign in_ready  = rst_n & (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign busy      = busy_q;

   always_comb begin
      state_d     = state_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      s_d         = s_q;
      sub_d       = sub_q;
      e_d         = e_q;
      ml_d        = ml_q;
      ms_d        = ms_q;
      cnt_d       = cnt_q;
      diff_d      = diff_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               opa_d   = a;
               opb_d   = {~b[31], b[30:0]};
               state_d = ALIGN;
            end
         end
         ALIGN: begin
            out_valid_d = 1'b1;
            state_d     = DONE;
            if (nan_any || inf_clash) begin
               diff_d = NAN_CODE;
            end else if (f32_is_inf(opa_q)) begin
               diff_d = {opa_q.sign, EXP_MAX, 23'h0};
            end else if (f32_is_inf(opb_q)) begin
               diff_d = {opb_q.sign, EXP_MAX, 23'h0};
            end else if (f32_is_zero(opa_q) && f32_is_zero(opb_q)) begin
               diff_d = {opa_q.sign & opb_q.sign, 31'h0};
            end else begin
               out_valid_d = 1'b0;
               state_d     = ADD;
               s_d         = op_l.sign;
               sub_d       = opa_q.sign ^ opb_q.sign;
               e_d         = op_l.exp;
               ml_d        = {1'b0, man_l};
               ms_d        = {1'b0, man_s_sh};
               cnt_d       = '0;
            end
         end
         ADD: begin
            out_valid_d = 1'b1;
            state_d     = DONE;
            if (!sub_q) begin
               if (!sum[MAN_W+1]) begin
                  diff_d = {s_q, e_q, sum[MAN_W-1:0]};
               end else if (e_q == EXP_MAX - 8'd1) begin
                  diff_d = {s_q, EXP_MAX, 23'h0};
               end else begin
                  diff_d = {s_q, e_q + 8'd1, sum[MAN_W:1]};
               end
            end else if (dif == '0) begin
               diff_d = '0;
            end else if (dif[MAN_W]) begin
               diff_d = {s_q, e_q, dif[MAN_W-1:0]};
            end else begin
               out_valid_d = 1'b0;
               state_d     = NORM;
               ml_d        = dif;
            end
         end
         NORM: begin
            // One shift per cycle; stop before the exponent would leave the normal range.
            if ((e_q == 8'd1) || (cnt_q == 5'(MAX_NORM))) begin
               diff_d      = '0;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               ml_d  = m_sh;
               e_d   = e_dec;
               cnt_d = cnt_q + 5'd1;
               if (m_sh[MAN_W]) begin
                  diff_d      = {s_q, e_dec, m_sh[MAN_W-1:0]};
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         opa_q       <= '0;
         opb_q       <= '0;
         s_q         <= 1'b0;
         sub_q       <= 1'b0;
         e_q         <= '0;
         ml_q        <= '0;
         ms_q        <= '0;
         cnt_q       <= '0;
         diff_q      <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         s_q         <= s_d;
         sub_q       <= sub_d;
         e_q         <= e_d;
         ml_q        <= ml_d;
         ms_q        <= ms_d;
         cnt_q       <= cnt_d;
         diff_q      <= diff_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_subf32_seq.sv
// Bench for subf32_seq: directed vector table, hold/reset sequences, then random
// operands against an arithmetic reference model.
module tb_subf32_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] diff;
   logic        busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[$];

   subf32_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Result of a - b from the operand-level rules: truncating alignment, exact
   // integer add/subtract, then normalisation with flush to +0.
   function automatic void ref_model(input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] r_out, output int lat);
      logic   sx, sy, sl, ss;
      int     ex, ey, el, es, e, d, shifts;
      longint mx, my, ml, ms, r;
      bit     flushed;
      sx = x[31];
      sy = ~y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      mx = (ex == 0) ? 0 : longint'(x[22:0]) + 8388608;
      my = (ey == 0) ? 0 : longint'(y[22:0]) + 8388608;
      lat = 2;
      if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0)) r_out = 32'h7FC00000;
      else if (ex == 255 && ey == 255 && sx != sy) r_out = 32'h7FC00000;
      else if (ex == 255) r_out = {sx, 8'hFF, 23'h0};
      else if (ey == 255) r_out = {sy, 8'hFF, 23'h0};
      else if (ex == 0 && ey == 0) r_out = {sx & sy, 31'h0};
      else begin
         lat = 3;
         if (ey > ex || (ey == ex && my > mx)) begin
            sl = sy; el = ey; ml = my; ss = sx; es = ex; ms = mx;
         end else begin
            sl = sx; el = ex; ml = mx; ss = sy; es = ey; ms = my;
         end
         d  = el - es;
         ms = (d >= 24) ? 0 : ms / (longint'(1) << d);
         e  = el;
         if (sl == ss) begin
            r = ml + ms;
            if (r >= 16777216) begin
               r = r / 2;
               e = e + 1;
            end
            r_out = (e >= 255) ? {sl, 8'hFF, 23'h0} : {sl, 8'(e), 23'(r % 8388608)};
         end else begin
            r = ml - ms;
            if (r == 0) r_out = 32'h0;
            else begin
               shifts  = 0;
               flushed = 0;
               while (r < 8388608 && !flushed) begin
                  lat++;
                  if (e == 1 || shifts == 23) flushed = 1;
                  else begin
                     r = r * 2;
                     e = e - 1;
                     shifts++;
                  end
               end
               r_out = flushed ? 32'h0 : {sl, 8'(e), 23'(r % 8388608)};
            end
         end
      end
   endfunction

   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] exp_y,
                         input int exp_lat, input int hold, input string name);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      a = ta;
      b = tb;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      n = 1;
      while (!out_valid && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, " out_valid"}, 64'(out_valid), 64'd1);
      chk({name, " diff"}, 64'(diff), 64'(exp_y));
      chk({name, " latency"}, 64'(n), 64'(exp_lat));
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         @(posedge clk); #1;
         chk({name, " hold {out_valid,in_ready,diff}"}, {30'h0, out_valid, in_ready, diff},
             {30'h0, 1'b1, 1'b0, exp_y});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, " released {out_valid,diff}"}, {31'h0, out_valid, diff}, {31'h0, 1'b0, exp_y});
   endtask

   initial begin
      logic [31:0] ra, rb, ry;
      int          rlat;
      logic [7:0]  ex8;

      vecs.push_back('{32'h40400000, 32'h3F800000, 32'h40000000, 3, "3.0-1.0"});
      vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h00000000, 3, "1.0-1.0"});
      vecs.push_back('{32'h3F800000, 32'hBF800000, 32'h40000000, 3, "1.0+1.0 carry"});
      vecs.push_back('{32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 26, "23 norm shifts"});
      vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, 2, "inf-inf"});
      vecs.push_back('{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 3, "overflow to inf"});
      vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2, "nan in"});
      vecs.push_back('{32'h7F800000, 32'hFF800000, 32'h7F800000, 2, "inf+inf"});
      vecs.push_back('{32'h3F800000, 32'h7F800000, 32'hFF800000, 2, "1-inf"});
      vecs.push_back('{32'h00000000, 32'h00000000, 32'h00000000, 2, "+0-+0"});
      vecs.push_back('{32'h80000000, 32'h00000000, 32'h80000000, 2, "-0-+0"});
      vecs.push_back('{32'h00000001, 32'h00000000, 32'h00000000, 2, "denormal flush"});
      vecs.push_back('{32'h00000000, 32'h3F800000, 32'hBF800000, 3, "0-1.0"});
      vecs.push_back('{32'h4B800000, 32'h3F800000, 32'h4B800000, 3, "shift 24"});
      vecs.push_back('{32'h4B000000, 32'h3F800000, 32'h4AFFFFFE, 4, "shift 23"});
      vecs.push_back('{32'h00800001, 32'h00800000, 32'h00000000, 4, "underflow flush"});

      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset diff", 64'(diff), 64'd0);
      chk("reset in_ready low", 64'(in_ready), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("post-reset in_ready", 64'(in_ready), 64'd1);

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].lat, 0, vecs[i].name);
      end

      // Consumer stalls for 5 cycles while a new operand is offered.
      run_op(32'h40400000, 32'h3F800000, 32'h40000000, 3, 5, "stall");

      // Reset in the middle of normalisation discards the operation.
      a = 32'h3F800000;
      b = 32'h3F7FFFFF;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("mid-norm {busy,out_valid}", {62'h0, busy, out_valid}, {62'h0, 1'b1, 1'b0});
      rst_n = 1'b0;
      #1;
      chk("in_ready during reset", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("after reset {out_valid,in_ready,busy}", {61'h0, out_valid, in_ready, busy},
          {61'h0, 1'b0, 1'b1, 1'b0});
      chk("after reset diff", 64'(diff), 64'd0);
      run_op(32'h40400000, 32'h3F800000, 32'h40000000, 3, 0, "post-reset op");

      for (int i = 0; i < 200; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 3))
            0: rb[30:23] = ra[30:23];
            1: begin
               ex8 = ra[30:23] - 8'd1;
               rb[30:23] = ex8;
            end
            2: rb = ra ^ (32'h1 << $urandom_range(0, 6));
            default: ;
         endcase
         if ($urandom_range(0, 1) == 1) rb[31] = ~rb[31];
         ref_model(ra, rb, ry, rlat);
         run_op(ra, rb, ry, rlat, $urandom_range(0, 3), $sformatf("rand%0d %h-%h", i, ra, rb));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
